// File: rtl/aes_pkg.sv
// Shared AES byte-level definitions: widths, FSM encoding and both S-box lookup tables.
// Pure combinational functions; no clocked logic lives here.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sbi_state_t;

    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        logic [7:0] s;
        s = 8'h00;
        case (b)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] s;
        s = 8'h00;
        case (b)
            8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
            8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
            8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
            8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
            8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
            8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
            8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
            8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
            8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
            8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
            8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
            8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
            8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
            8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
            8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
            8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
            8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
            8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
            8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
            8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
            8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
            8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
            8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
            8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
            8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
            8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
            8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
            8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
            8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
            8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
            8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
            8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sub_bytes_iter_if.sv
// Block handshake bundle for the SubBytes engine: valid/ready in, valid/ready out.
// slave = engine side, master = producer/consumer side.
interface sub_bytes_iter_if;
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_STATE_W-1:0] in_data;
    logic                   in_inv;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_STATE_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_sbox.sv
// One byte through the forward or inverse AES S-box; purely combinational, zero latency.
// No flow control: the parent owns all handshaking.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] i_byte,
    input  logic                  i_inv,
    output logic [AES_BYTE_W-1:0] o_byte
);
    assign o_byte = i_inv ? inv_sbox(i_byte) : fwd_sbox(i_byte);
endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes, LANES bytes per cycle; result valid NSTEP cycles after accept.
// Result held in DONE until out_ready; a new block may be accepted in the same cycle.
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    sub_bytes_iter_if.slave  bus
);
    localparam int NSTEP = 16 / LANES;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    sbi_state_t             r_fsm;
    logic [AES_STATE_W-1:0] r_blk;
    logic [CW-1:0]          r_cnt;
    logic                   r_mode;
    logic                   r_out_vld;
    logic                   w_in_rdy;

    logic [AES_BYTE_W-1:0]  w_lane_in  [LANES];
    logic [AES_BYTE_W-1:0]  w_lane_out [LANES];
    logic [6:0]             w_lane_pos [LANES];

    // Lane g works on byte cnt*LANES+g; w_lane_pos is its bit offset.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_lane_pos[g] = 7'((int'(r_cnt) * LANES + g) * AES_BYTE_W);
        assign w_lane_in[g]  = r_blk[w_lane_pos[g] +: AES_BYTE_W];
        aes_sbox u_sbox (
            .i_byte (w_lane_in[g]),
            .i_inv  (r_mode),
            .o_byte (w_lane_out[g])
        );
    end

    assign w_in_rdy      = (r_fsm == IDLE) || ((r_fsm == DONE) && bus.out_ready);
    assign bus.in_ready  = w_in_rdy;
    assign bus.out_valid = r_out_vld;
    assign bus.out_data  = r_blk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm     <= IDLE;
            r_blk     <= '0;
            r_cnt     <= '0;
            r_mode    <= 1'b0;
            r_out_vld <= 1'b0;
        end else if (clr) begin
            r_fsm     <= IDLE;
            r_cnt     <= '0;
            r_out_vld <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_blk  <= bus.in_data;
                        r_mode <= bus.in_inv;
                        r_cnt  <= '0;
                        r_fsm  <= BUSY;
                    end
                end
                BUSY: begin
                    for (int l = 0; l < LANES; l++) begin
                        r_blk[w_lane_pos[l] +: AES_BYTE_W] <= w_lane_out[l];
                    end
                    if (r_cnt == LAST) begin
                        r_cnt     <= '0;
                        r_fsm     <= DONE;
                        r_out_vld <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_vld <= 1'b0;
                        if (bus.in_valid) begin
                            r_blk  <= bus.in_data;
                            r_mode <= bus.in_inv;
                            r_cnt  <= '0;
                            r_fsm  <= BUSY;
                        end else begin
                            r_fsm <= IDLE;
                        end
                    end
                end
                default: begin
                    r_fsm     <= IDLE;
                    r_out_vld <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed vector bench for sub_bytes_iter: LANES=4 main instance plus a LANES=1/2/8/16 sweep.
module tb_sub_bytes_iter;

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic clr;

    int n_chk  = 0;
    int n_fail = 0;

    sub_bytes_iter_if bif();
    sub_bytes_iter #(.LANES(4)) u_dut (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bif));

    logic         sw_valid;
    logic         sw_inv;
    logic         sw_out_ready;
    logic [127:0] sw_data;

    sub_bytes_iter_if s1();
    sub_bytes_iter_if s2();
    sub_bytes_iter_if s8();
    sub_bytes_iter_if s16();
    assign s1.in_valid  = sw_valid; assign s1.in_data  = sw_data; assign s1.in_inv  = sw_inv; assign s1.out_ready  = sw_out_ready;
    assign s2.in_valid  = sw_valid; assign s2.in_data  = sw_data; assign s2.in_inv  = sw_inv; assign s2.out_ready  = sw_out_ready;
    assign s8.in_valid  = sw_valid; assign s8.in_data  = sw_data; assign s8.in_inv  = sw_inv; assign s8.out_ready  = sw_out_ready;
    assign s16.in_valid = sw_valid; assign s16.in_data = sw_data; assign s16.in_inv = sw_inv; assign s16.out_ready = sw_out_ready;

    sub_bytes_iter #(.LANES(1))  u_l1  (.clk(clk), .rst_n(rst_n), .clr(1'b0), .bus(s1));
    sub_bytes_iter #(.LANES(2))  u_l2  (.clk(clk), .rst_n(rst_n), .clr(1'b0), .bus(s2));
    sub_bytes_iter #(.LANES(8))  u_l8  (.clk(clk), .rst_n(rst_n), .clr(1'b0), .bus(s8));
    sub_bytes_iter #(.LANES(16)) u_l16 (.clk(clk), .rst_n(rst_n), .clr(1'b0), .bus(s16));

    typedef struct packed {
        logic [127:0] din;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Caller is #1 after a posedge with the engine ready; takes the result after it appears.
    task automatic run_block(input logic [127:0] d, input logic inv,
                             output logic [127:0] res, output int lat);
        bif.in_valid = 1'b1;
        bif.in_data  = d;
        bif.in_inv   = inv;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        lat = 0;
        while (!bif.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bif.out_data;
        bif.out_ready = 1'b1;
        @(posedge clk); #1;
        bif.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] res;
        logic [127:0] fwd;
        logic [127:0] blk;
        logic [127:0] hold;
        int           lat;
        int           lat_sw [4];
        logic         seen;
        logic         stable;

        tbl[0] = {FIPS_IN,  1'b0, FIPS_OUT};
        tbl[1] = {FIPS_OUT, 1'b1, FIPS_IN};
        tbl[2] = {128'h0,   1'b0, {16{8'h63}}};
        tbl[3] = {{16{8'hff}}, 1'b0, {16{8'h16}}};
        tbl[4] = {{16{8'h53}}, 1'b0, {16{8'hed}}};
        tbl[5] = {{16{8'h63}}, 1'b1, 128'h0};
        tbl[6] = {128'h0,   1'b1, {16{8'h52}}};
        tbl[7] = {{16{8'h16}}, 1'b1, {16{8'hff}}};
        tbl[8] = {128'h0f0e0d0c0b0a09080706050403020100, 1'b0, 128'h76abd7fe2b670130c56f6bf27b777c63};

        rst_n = 1'b0; clr = 1'b0;
        bif.in_valid = 1'b0; bif.in_data = '0; bif.in_inv = 1'b0; bif.out_ready = 1'b0;
        sw_valid = 1'b0; sw_data = '0; sw_inv = 1'b0; sw_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready",  128'(bif.in_ready),  128'd1);
        check("reset_out_valid", 128'(bif.out_valid), 128'd0);
        check("reset_out_data",  bif.out_data,        128'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_block(tbl[i].din, tbl[i].inv, res, lat);
            check($sformatf("vec%0d_data", i), res, tbl[i].exp);
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'd4);
        end

        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 16; k++) blk[8*k +: 8] = 8'(b * 16 + k);
            run_block(blk, 1'b0, fwd, lat);
            run_block(fwd, 1'b1, res, lat);
            check($sformatf("roundtrip%0d", b), res, blk);
        end

        // Backpressure with a second block waiting, then same-cycle take and accept.
        bif.in_valid = 1'b1; bif.in_data = FIPS_IN; bif.in_inv = 1'b0;
        @(posedge clk); #1;
        bif.in_data = FIPS_OUT; bif.in_inv = 1'b1;
        lat = 0;
        while (!bif.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check("bp_first_latency", 128'(lat), 128'd4);
        hold = bif.out_data;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bif.out_data !== FIPS_OUT || bif.in_ready !== 1'b0 || bif.out_valid !== 1'b1) stable = 1'b0;
        end
        check("bp_hold_data", hold, FIPS_OUT);
        check("bp_hold_stable", 128'(stable), 128'd1);
        bif.out_ready = 1'b1;
        #1;
        check("bp_in_ready_follows_out_ready", 128'(bif.in_ready), 128'd1);
        @(posedge clk); #1;
        bif.out_ready = 1'b0; bif.in_valid = 1'b0;
        check("b2b_out_valid_dropped", 128'(bif.out_valid), 128'd0);
        check("b2b_second_accepted", 128'(bif.in_ready), 128'd0);
        lat = 0;
        while (!bif.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check("b2b_second_latency", 128'(lat), 128'd4);
        check("b2b_second_data", bif.out_data, FIPS_IN);
        bif.out_ready = 1'b1; @(posedge clk); #1; bif.out_ready = 1'b0;

        sw_valid = 1'b1; sw_data = '0; sw_inv = 1'b0;
        @(posedge clk); #1;
        sw_valid = 1'b0;
        for (int s = 0; s < 4; s++) lat_sw[s] = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (s1.out_valid  && lat_sw[0] == 0) lat_sw[0] = c;
            if (s2.out_valid  && lat_sw[1] == 0) lat_sw[1] = c;
            if (s8.out_valid  && lat_sw[2] == 0) lat_sw[2] = c;
            if (s16.out_valid && lat_sw[3] == 0) lat_sw[3] = c;
        end
        check("sweep_l1_latency",  128'(lat_sw[0]), 128'd16);
        check("sweep_l2_latency",  128'(lat_sw[1]), 128'd8);
        check("sweep_l8_latency",  128'(lat_sw[2]), 128'd2);
        check("sweep_l16_latency", 128'(lat_sw[3]), 128'd1);
        check("sweep_l1_data",  s1.out_data,  {16{8'h63}});
        check("sweep_l2_data",  s2.out_data,  {16{8'h63}});
        check("sweep_l8_data",  s8.out_data,  {16{8'h63}});
        check("sweep_l16_data", s16.out_data, {16{8'h63}});
        sw_out_ready = 1'b1; @(posedge clk); #1; sw_out_ready = 1'b0;

        // Abort on the second BUSY cycle.
        bif.in_valid = 1'b1; bif.in_data = FIPS_IN; bif.in_inv = 1'b0;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_idle_in_ready", 128'(bif.in_ready), 128'd1);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (bif.out_valid) seen = 1'b1;
        end
        check("clr_no_out_valid", 128'(seen), 128'd0);
        run_block(FIPS_IN, 1'b0, res, lat);
        check("clr_next_data", res, FIPS_OUT);
        check("clr_next_latency", 128'(lat), 128'd4);

        bif.in_valid = 1'b1; bif.in_data = FIPS_IN; bif.in_inv = 1'b0;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0; #1;
        check("rst_busy_in_ready",  128'(bif.in_ready),  128'd1);
        check("rst_busy_out_valid", 128'(bif.out_valid), 128'd0);
        check("rst_busy_out_data",  bif.out_data,        128'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        bif.in_valid = 1'b1; bif.in_data = FIPS_IN; bif.in_inv = 1'b0;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        lat = 0;
        while (!bif.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check("rst_done_reached", 128'(bif.out_valid), 128'd1);
        #2;
        rst_n = 1'b0; #1;
        check("rst_done_out_valid", 128'(bif.out_valid), 128'd0);
        check("rst_done_out_data",  bif.out_data,        128'h0);
        check("rst_done_in_ready",  128'(bif.in_ready),  128'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(FIPS_OUT, 1'b1, res, lat);
        check("post_reset_data", res, FIPS_IN);
        check("post_reset_latency", 128'(lat), 128'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sub_bytes_iter.md
Name: sub_bytes_iter

Overview:
- Iterative, parametrised AES SubBytes engine. It substitutes one 128-bit state through a byte S-box, LANES bytes per cycle.
- Supports forward (encrypt) and inverse (decrypt) substitution, selected per block.
- Uses valid/ready handshakes on input and output.
- Sits between the round-key/ShiftRows datapath and the round controller. It trades area (fewer S-box instances) for latency.

Parameters:
- LANES, 4, S-box instances, i.e. bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- NSTEP, 16/LANES, derived localparam (not overridable): substitution cycles per block.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data/in_inv are valid
- in_ready  output  1  engine can accept a block this cycle
- in_data  input  128  state; byte k = in_data[8k+7:8k]
- in_inv  input  1  0 = forward S-box, 1 = inverse S-box; captured with in_data
- out_valid  output  1  out_data holds a finished block
- out_ready  input  1  consumer accepts out_data
- out_data  output  128  substituted state, same byte mapping as in_data
- clr  input  1  synchronous abort; discards any block in flight

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is asynchronous and active-low.
  - Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, internal state register=0, step counter=0, mode=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load in_data into the state register, latch in_inv into mode, counter=0, go BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each cycle, bytes [cnt*LANES .. cnt*LANES+LANES-1] of the state register are replaced by sbox(byte, mode); counter increments.
  - When counter==NSTEP-1, the final group is written and the FSM goes to DONE.
  - Untouched bytes hold. Mode is constant for the whole block.
- DONE:
  - out_valid=1, and out_data = state register, held stable until out_valid&&out_ready.
  - in_ready = out_ready, so a new block can be accepted in the same cycle the result is taken.
  - On out_ready: if in_valid is also high, load the new block and go BUSY; otherwise go IDLE.
- Latency: out_valid rises exactly NSTEP cycles after the accepting edge. LANES=4 gives 4 cycles; LANES=16 gives 1 cycle.
- Throughput: back-to-back blocks complete one per NSTEP+1 cycles.
- out_data is driven from the register only; no combinational path from in_data to out_data.
- Backpressure: out_ready low in DONE holds everything indefinitely, with no data change.
- clr:
  - Highest priority after reset. Next state is IDLE, out_valid=0, counter=0.
  - State register is left unchanged and is don't-care. Any handshake in the same cycle is ignored.
- in_valid in BUSY is ignored. The source must hold it until in_ready is seen.
- Reset mid-BUSY or in DONE: immediate return to reset values; the block is lost.
- S-box:
  - Forward is the FIPS-197 S-box (0x00->0x63, 0x53->0xed, 0xff->0x16).
  - Inverse is its exact inverse (0x63->0x00, 0x00->0x52, 0x16->0xff).
  - Both are pure case-table lookups, with no X on any input value.

Decomposition:
- Shared package aes_pkg:
  - forward S-box function fwd_sbox
  - inverse S-box function inv_sbox
  - state width constant AES_STATE_W=128
  - byte width constant AES_BYTE_W=8
- Sub-module aes_sbox (8-bit in, inv select, 8-bit out): combinational mux of the two package functions, instantiated LANES times via generate.

Test Plan:
- Forward, LANES=4: in_data=193de3bea0f4e22b9ac68d2ae9f84808, in_inv=0 -> out_data=d42711aee0bf98f1b8b45de51e415230, out_valid exactly 4 cycles after the accept.
- Inverse round-trip: feed d42711aee0bf98f1b8b45de51e415230 with in_inv=1 -> 193de3bea0f4e22b9ac68d2ae9f84808. Exhaustive: 16 blocks covering bytes 0x00..0xff, forward then inverse, must return the originals.
- Backpressure/back-to-back:
  - Hold out_ready=0 for 10 cycles -> out_data stable, in_ready=0.
  - Raise out_ready with in_valid=1 -> result taken and new block accepted in the same cycle; next out_valid 4 cycles later.
- Parameter sweep LANES=1,2,8,16 with the all-zero block -> out_data=16 bytes of 0x63, latencies 16, 8, 2, 1.
- clr asserted on cycle 2 of BUSY -> IDLE next cycle, out_valid never rises; the following block is processed correctly.
- rst_n pulsed low asynchronously mid-BUSY and in DONE -> outputs at reset values immediately; normal operation after release.
